// File: rtl/universal_shift_register.sv
// rtl/universal_shift_register.sv - WIDTH-bit universal shift register with enable, mode select and true/complement outputs
module universal_shift_register #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             E,
    input  logic [2:0]       M,
    input  logic [WIDTH-1:0] D,
    input  logic             SIR,
    input  logic             SIL,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] P,
    output logic             SO,
    output logic             ZERO
);

    if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
        $error("universal_shift_register: WIDTH must be in 2..64");
    end

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROTR  = 3'b100;
    localparam logic [2:0] MODE_ROTL  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_SET   = 3'b111;

    // SO only changes on modes that push a bit out of the register
    always_ff @(posedge CLK) begin
        if (RST) begin
            Q  <= RESET_VALUE;
            SO <= 1'b0;
        end else if (E) begin
            case (M)
                MODE_HOLD: begin
                    Q <= Q;
                end
                MODE_SHR: begin
                    Q  <= {SIR, Q[WIDTH-1:1]};
                    SO <= Q[0];
                end
                MODE_SHL: begin
                    Q  <= {Q[WIDTH-2:0], SIL};
                    SO <= Q[WIDTH-1];
                end
                MODE_LOAD: begin
                    Q <= D;
                end
                MODE_ROTR: begin
                    Q  <= {Q[0], Q[WIDTH-1:1]};
                    SO <= Q[0];
                end
                MODE_ROTL: begin
                    Q  <= {Q[WIDTH-2:0], Q[WIDTH-1]};
                    SO <= Q[WIDTH-1];
                end
                MODE_CLEAR: begin
                    Q <= '0;
                end
                MODE_SET: begin
                    Q <= '1;
                end
                default: begin
                    Q <= Q;
                end
            endcase
        end
    end

    assign P    = ~Q;
    assign ZERO = (Q == '0);

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised clocked storage element. It is the edge-triggered, multi-bit successor to the single-bit gated D latch. The register holds WIDTH bits and is gated by an enable (E). A mode select chooses one of: hold, shift right, shift left, parallel load, rotate right, rotate left, clear, or set. Like the latch, it provides true (Q) and complement (P) outputs. It is the building block for serial/parallel converters and counters in the Digital Circuits library.

Parameters:
WIDTH, 8, register width in bits; legal range 2..64.
RESET_VALUE, 0, value loaded into Q on reset; WIDTH bits wide.

Ports:
CLK  input  1  clock; all state updates on rising edge.
RST  input  1  synchronous, active-high reset; sampled on rising CLK edge; overrides everything.
E  input  1  enable (gate); 0 = hold regardless of M.
M  input  3  mode select, see Behaviour.
D  input  WIDTH  parallel load data.
SIR  input  1  serial input for shift right; enters at MSB.
SIL  input  1  serial input for shift left; enters at LSB.
Q  output  WIDTH  register contents.
P  output  WIDTH  bitwise complement of Q, always ~Q (combinational from Q).
SO  output  1  registered copy of the last bit shifted or rotated out.
ZERO  output  1  1 when Q == 0 (combinational from Q).

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-high (RST). There is no asynchronous path.
- Reset values:
  - Q = RESET_VALUE.
  - P = ~RESET_VALUE.
  - SO = 0.
  - ZERO = (RESET_VALUE == 0).
- RST = 1 at an edge: reset values are applied; E, M, D, SIR and SIL are ignored that cycle.
- Reset mid-operation discards the operation in progress. There is no partial state.
- E = 0 at an edge (RST = 0): Q and SO hold.
- E = 1 at an edge: one operation per edge, selected by M:
  - 000 hold: Q and SO unchanged.
  - 001 shift right: Q <= {SIR, Q[WIDTH-1:1]}; SO <= old Q[0].
  - 010 shift left: Q <= {Q[WIDTH-2:0], SIL}; SO <= old Q[WIDTH-1].
  - 011 parallel load: Q <= D; SO unchanged.
  - 100 rotate right: Q <= {Q[0], Q[WIDTH-1:1]}; SO <= old Q[0].
  - 101 rotate left: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; SO <= old Q[WIDTH-1].
  - 110 clear: Q <= 0; SO unchanged.
  - 111 set: Q <= all ones; SO unchanged.
- Latency: one cycle. The new Q, P, SO and ZERO are visible after the edge at which the operation was sampled.
- P and ZERO track Q in the same cycle. No glitch requirement beyond normal combinational settling.
- X/Z on M while E = 1 is illegal. The bench flags it with an assertion and does not define a result.
- Back-to-back operations on consecutive edges are fully supported. Each edge sees the previous edge's Q.
- Wrap-around:
  - Rotates are lossless; WIDTH rotates return the original value.
  - Shifts are lossy; after WIDTH shifts, Q is fully replaced by serial input bits.
- Simultaneous events: the priority order is RST, then E, then M. There are no other simultaneous sources.
- WIDTH outside 2..64: elaboration error via a generate-time check.

Test Plan:
1. Reset (WIDTH=8, RESET_VALUE=8'hA5): RST=1 for 1 edge, E=1, M=011, D=8'hFF -> Q=8'hA5, P=8'h5A, SO=0, ZERO=0. The load is ignored.
2. Load and shift right: load D=8'b1001_0110, then 3 edges of M=001 with SIR=1,0,1 -> Q=8'b1011_0010. SO after each edge = 0, 1, 1.
3. Rotate wrap: load 8'h81, then 8 edges of M=101 -> Q=8'h81 again. After the first edge Q=8'h03 and SO=1.
4. Enable gating: load 8'h3C, E=0 with M=110 for 4 edges -> Q stays 8'h3C. Then E=1, M=110 -> Q=8'h00 and ZERO=1 on the next cycle.
5. Shift left fill: Q=8'h00, M=010, SIL=1 for 8 edges -> Q=8'hFF, P=8'h00. The ninth edge with SIL=0 -> Q=8'hFE, SO=1.
6. Reset mid-sequence: during a shift-right run, assert RST for 1 edge -> Q=RESET_VALUE and SO=0. The next edge resumes from RESET_VALUE. Repeat at WIDTH=2 and WIDTH=64 using the same relative checks.
